// File: rtl/motor_pwm_out.sv
// motor_pwm_out: two-channel servo PWM with double-buffered commands applied at period boundaries
module motor_pwm_out #(
  parameter int PERIOD_CYCLES = 2_000_000,
  parameter int REV_CYCLES    = 100_000,
  parameter int STOP_CYCLES   = 150_000,
  parameter int FWD_CYCLES    = 200_000,
  parameter int MIRROR_RIGHT  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_left,
  input  logic [1:0] cmd_right,
  output logic       motor_l,
  output logic       motor_r,
  output logic       period_start
);
  localparam int W = $clog2(PERIOD_CYCLES);
  localparam logic [W-1:0] LAST = W'(PERIOD_CYCLES - 1);
  localparam logic [W-1:0] REV  = W'(REV_CYCLES);
  localparam logic [W-1:0] STOP = W'(STOP_CYCLES);
  localparam logic [W-1:0] FWD  = W'(FWD_CYCLES);
  logic [W-1:0] cnt, cnt_nxt;
  logic run, start, pend_valid;
  logic [1:0] act_l, act_r, pend_l, pend_r, nxt_l, nxt_r;
  function automatic logic [W-1:0] width(input logic [1:0] c, input logic swap);
    return c == 2'b01 ? (swap ? REV : FWD) : c == 2'b10 ? (swap ? FWD : REV) : STOP;
  endfunction
  assign cmd_ready = !pend_valid;
  // outputs are registered from the index and command of the cycle about to begin
  always_comb begin
    start   = !run || cnt == LAST;
    cnt_nxt = start ? '0 : cnt + W'(1);
    nxt_l   = start && pend_valid ? pend_l : act_l;
    nxt_r   = start && pend_valid ? pend_r : act_r;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run          <= 1'b0;
      cnt          <= '0;
      act_l        <= 2'b00;
      act_r        <= 2'b00;
      pend_l       <= 2'b00;
      pend_r       <= 2'b00;
      pend_valid   <= 1'b0;
      motor_l      <= 1'b0;
      motor_r      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      run          <= 1'b1;
      cnt          <= cnt_nxt;
      period_start <= start;
      act_l        <= nxt_l;
      act_r        <= nxt_r;
      motor_l      <= cnt_nxt < width(nxt_l, 1'b0);
      motor_r      <= cnt_nxt < width(nxt_r, MIRROR_RIGHT != 0);
      if (cmd_valid && !pend_valid) begin
        pend_l     <= cmd_left;
        pend_r     <= cmd_right;
        pend_valid <= 1'b1;
      end else if (start) pend_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_motor_pwm_out.sv
// tb_motor_pwm_out: directed bench measuring per-period pulse widths against hand-computed values
module tb_motor_pwm_out;
  logic clk = 0, reset_n = 0, cmd_valid = 0;
  logic [1:0] cmd_left = 0, cmd_right = 0;
  logic cmd_ready, motor_l, motor_r, period_start;
  int errors = 0, checks = 0;
  int ph = 0, np = -1, cl, cr, cn;
  bit live = 0;
  int hl[16], hr[16], ln[16];
  bit got[16], fl[16], fr[16];

  motor_pwm_out #(.PERIOD_CYCLES(100), .REV_CYCLES(10), .STOP_CYCLES(15),
                  .FWD_CYCLES(20), .MIRROR_RIGHT(1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_left(cmd_left), .cmd_right(cmd_right), .motor_l(motor_l), .motor_r(motor_r),
    .period_start(period_start));

  always #5 clk = ~clk;

  // per-period monitor; a period cut short by reset is never recorded
  always @(negedge clk) begin
    if (!reset_n) live = 0;
    else if (period_start) begin
      if (live && np >= 0 && np < 16) begin
        hl[np] = cl; hr[np] = cr; ln[np] = cn; got[np] = 1;
      end
      live = 1; np++; ph = 0; cl = 0; cr = 0; cn = 0;
      if (np < 16) begin fl[np] = motor_l; fr[np] = motor_r; end
    end else ph++;
    if (reset_n && live) begin cl += int'(motor_l); cr += int'(motor_r); cn++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_at(input int p, input int k);
    for (int i = 0; i < 400; i++) begin
      step();
      if (np == p && ph == k) return;
    end
    chk($sformatf("timeout p%0d c%0d", p, k), 0, 1);
  endtask

  int exp_l[11] = '{15, 15, 15, 20, 20, 10, 15, 20, 0, 15, 15};
  int exp_r[11] = '{15, 15, 15, 10, 10, 20, 15, 10, 0, 15, 15};

  initial begin
    repeat (3) step();
    chk("rst motor_l", motor_l, 0);
    chk("rst motor_r", motor_r, 0);
    chk("rst period_start", period_start, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    reset_n = 1;
    step();
    chk("first period_start", period_start, 1);
    chk("first motor_l", motor_l, 1);
    chk("first motor_r", motor_r, 1);
    wait_at(2, 40);
    cmd_valid = 1; cmd_left = 2'b01; cmd_right = 2'b01;
    step();
    chk("ready low after transfer", cmd_ready, 0);
    cmd_valid = 0; cmd_left = 2'b11; cmd_right = 2'b10;
    wait_at(2, 99);
    chk("ready low end of period", cmd_ready, 0);
    step();
    chk("ready back at period start", cmd_ready, 1);
    wait_at(3, 99);
    cmd_valid = 1; cmd_left = 2'b10; cmd_right = 2'b10;
    step();
    chk("ready low after start-edge transfer", cmd_ready, 0);
    cmd_left = 2'b11; cmd_right = 2'b11;
    wait_at(5, 0);
    chk("ready back after held period", cmd_ready, 1);
    step();
    chk("held cmd captured", cmd_ready, 0);
    cmd_valid = 0; cmd_left = 2'b00; cmd_right = 2'b00;
    wait_at(6, 50);
    cmd_valid = 1; cmd_left = 2'b01; cmd_right = 2'b01;
    step();
    cmd_valid = 0;
    wait_at(7, 99);
    cmd_valid = 1; cmd_left = 2'b10; cmd_right = 2'b10;
    step();
    cmd_valid = 0;
    wait_at(8, 5);
    chk("mid pulse motor_l", motor_l, 1);
    chk("mid pulse ready", cmd_ready, 0);
    reset_n = 0;
    #1;
    chk("async rst motor_l", motor_l, 0);
    chk("async rst motor_r", motor_r, 0);
    chk("async rst ready", cmd_ready, 1);
    repeat (2) step();
    reset_n = 1;
    wait_at(11, 0);
    for (int p = 0; p < 11; p++) begin
      if (p == 8) continue;
      chk($sformatf("p%0d recorded", p), got[p], 1);
      chk($sformatf("p%0d len", p), ln[p], 100);
      chk($sformatf("p%0d motor_l width", p), hl[p], exp_l[p]);
      chk($sformatf("p%0d motor_r width", p), hr[p], exp_r[p]);
      chk($sformatf("p%0d starts high", p), {30'b0, fl[p], fr[p]}, 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
